// File: rtl/rlnn_pkg.sv
// Shared types for the replay sequencer: FSM states and the stored experience tuple.
// Field widths here are the build defaults; the top re-declares them per instance.
package rlnn_pkg;

  localparam int DATA_W = 4;
  localparam int N_IN   = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MODEL,
    S_GAP,
    S_TARGET,
    S_TRAIN,
    S_DONE
  } fsm_e;

  typedef struct packed {
    logic [N_IN*DATA_W-1:0] state;
    logic [N_IN*DATA_W-1:0] next_state;
    logic                   action;
    logic [DATA_W-1:0]      reward;
  } exp_t;

endpackage

// File: rtl/replay_mem.sv
// Circular experience store: one write port, one registered read port.
// The read register doubles as the latched sample and reads old data on a same-slot write.
module replay_mem
  import rlnn_pkg::*;
#(
  parameter int  DEPTH   = 8,
  parameter type entry_t = exp_t,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  entry_t        wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output entry_t        rd_data
);

  entry_t mem [DEPTH];

  // storage array write
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // sample register, held between loads
  always_ff @(posedge clk) begin
    if (rst_b)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/replay_sequencer.sv
// Replay buffer plus training-step sequencer driving a model/target network pair.
// Define REPLAY_OVERWRITE_EN to let a full buffer overwrite its oldest entry.
module replay_sequencer
  import rlnn_pkg::*;
#(
  parameter int  DATA_WIDTH         = 4,
  parameter int  NEURON_INPUT_LAYER = 2,
  parameter int  DEPTH              = 8,
  parameter int  TIMEOUT            = 255,
  localparam int IW                 = NEURON_INPUT_LAYER * DATA_WIDTH,
  localparam int CW                 = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  exp_valid,
  output logic                  exp_ready,
  input  logic [IW-1:0]         exp_state,
  input  logic [IW-1:0]         exp_next_state,
  input  logic                  exp_action,
  input  logic [DATA_WIDTH-1:0] exp_reward,
  input  logic                  start,
  output logic                  busy,
  output logic [IW-1:0]         nn_input,
  output logic                  input_enable,
  output logic                  use_target,
  output logic                  is_training,
  input  logic                  model_fwd_done,
  input  logic                  target_fwd_done,
  input  logic                  training_done,
  output logic                  sel_action,
  output logic [DATA_WIDTH-1:0] sel_reward,
  output logic                  step_done,
  output logic                  timeout_err,
  output logic [CW-1:0]         count
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic [IW-1:0]         state;
    logic [IW-1:0]         next_state;
    logic                  action;
    logic [DATA_WIDTH-1:0] reward;
  } entry_t;

  fsm_e          state, state_nxt;
  logic [AW-1:0] wr_ptr, smp_ptr, smp_nxt;
  logic [AW-1:0] oldest, newest;
  logic [TW-1:0] wait_cnt;
  logic          full, wr_fire, evict, load;
  logic          waiting, wait_done, tmo;
  entry_t        wr_data, rd_data;

  assign full    = (count == CW'(DEPTH));
  assign wr_fire = exp_valid && exp_ready;
  assign oldest  = wr_ptr - count[AW-1:0];
  assign newest  = wr_ptr - 1'b1;
  assign load    = (state == S_LOAD);

`ifdef REPLAY_OVERWRITE_EN
  assign exp_ready = 1'b1;
  assign evict     = wr_fire && full;
`else
  assign exp_ready = !full;
  assign evict     = 1'b0;
`endif

  assign wr_data = '{
    state:      exp_state,
    next_state: exp_next_state,
    action:     exp_action,
    reward:     exp_reward
  };

  replay_mem #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_mem (
    .clk     (clk),
    .rst_b   (rst_b),
    .wr_en   (wr_fire && !rst_b),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_en   (load),
    .rd_addr (smp_ptr),
    .rd_data (rd_data)
  );

  // next sample slot: walk oldest..newest, skip a slot evicted under it
  always_comb begin
    smp_nxt = smp_ptr;
    if (load) begin
      smp_nxt = (smp_ptr == newest) ? oldest : smp_ptr + 1'b1;
    end
    if (evict && smp_nxt == wr_ptr) smp_nxt = wr_ptr + 1'b1;
  end

  // ring pointers and fill level
  always_ff @(posedge clk) begin
    if (rst_b) begin
      wr_ptr  <= '0;
      smp_ptr <= '0;
      count   <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (!full) count <= count + 1'b1;
      end
      smp_ptr <= smp_nxt;
    end
  end

  assign waiting   = (state == S_MODEL) ||
                     (state == S_TARGET) ||
                     (state == S_TRAIN);
  assign wait_done = (state == S_MODEL  && model_fwd_done)  ||
                     (state == S_TARGET && target_fwd_done) ||
                     (state == S_TRAIN  && training_done);
  assign tmo       = waiting && !wait_done &&
                     (wait_cnt == TW'(TIMEOUT - 1));

  // per-state wait counter, restarted whenever the state changes
  always_ff @(posedge clk) begin
    if (rst_b)                   wait_cnt <= '0;
    else if (state_nxt != state) wait_cnt <= '0;
    else if (waiting)            wait_cnt <= wait_cnt + 1'b1;
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst_b) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (start && count != '0) state_nxt = S_LOAD;
      S_LOAD:   state_nxt = S_MODEL;
      S_MODEL: begin
        if (model_fwd_done) state_nxt = S_GAP;
        else if (tmo)       state_nxt = S_IDLE;
      end
      S_GAP:    state_nxt = S_TARGET;
      S_TARGET: begin
        if (target_fwd_done) state_nxt = S_TRAIN;
        else if (tmo)        state_nxt = S_IDLE;
      end
      S_TRAIN: begin
        if (training_done) state_nxt = S_DONE;
        else if (tmo)      state_nxt = S_IDLE;
      end
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // network-facing and status outputs
  always_comb begin
    busy         = (state != S_IDLE);
    input_enable = 1'b0;
    use_target   = 1'b0;
    is_training  = 1'b0;
    step_done    = 1'b0;
    nn_input     = '0;
    timeout_err  = tmo;
    unique case (state)
      S_MODEL: begin
        input_enable = 1'b1;
        nn_input     = rd_data.state;
      end
      S_TARGET: begin
        input_enable = 1'b1;
        use_target   = 1'b1;
        nn_input     = rd_data.next_state;
      end
      S_TRAIN: begin
        use_target  = 1'b1;
        is_training = 1'b1;
      end
      S_DONE:  step_done = 1'b1;
      default: ;
    endcase
  end

  assign sel_action = rd_data.action;
  assign sel_reward = rd_data.reward;

endmodule

// File: tb/tb_replay_sequencer.sv
// Bench for replay_sequencer: directed steps plus random traffic checked
// against a sequence-number model of the replay buffer.
module tb_replay_sequencer;

  localparam int DW      = 4;
  localparam int NI      = 2;
  localparam int IW      = NI * DW;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 255;
  localparam int CW      = $clog2(DEPTH + 1);
`ifdef REPLAY_OVERWRITE_EN
  localparam bit OVW = 1'b1;
`else
  localparam bit OVW = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_b = 1'b1;
  logic          exp_valid = 1'b0;
  logic          exp_ready;
  logic [IW-1:0] exp_state = '0;
  logic [IW-1:0] exp_next_state = '0;
  logic          exp_action = 1'b0;
  logic [DW-1:0] exp_reward = '0;
  logic          start = 1'b0;
  logic          busy;
  logic [IW-1:0] nn_input;
  logic          input_enable, use_target, is_training;
  logic          model_fwd_done = 1'b0;
  logic          target_fwd_done = 1'b0;
  logic          training_done = 1'b0;
  logic          sel_action;
  logic [DW-1:0] sel_reward;
  logic          step_done, timeout_err;
  logic [CW-1:0] count;

  replay_sequencer #(
    .DATA_WIDTH         (DW),
    .NEURON_INPUT_LAYER (NI),
    .DEPTH              (DEPTH),
    .TIMEOUT            (TIMEOUT)
  ) dut (
    .clk             (clk),
    .rst_b           (rst_b),
    .exp_valid       (exp_valid),
    .exp_ready       (exp_ready),
    .exp_state       (exp_state),
    .exp_next_state  (exp_next_state),
    .exp_action      (exp_action),
    .exp_reward      (exp_reward),
    .start           (start),
    .busy            (busy),
    .nn_input        (nn_input),
    .input_enable    (input_enable),
    .use_target      (use_target),
    .is_training     (is_training),
    .model_fwd_done  (model_fwd_done),
    .target_fwd_done (target_fwd_done),
    .training_done   (training_done),
    .sel_action      (sel_action),
    .sel_reward      (sel_reward),
    .step_done       (step_done),
    .timeout_err     (timeout_err),
    .count           (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IW-1:0] st;
    logic [IW-1:0] nx;
    logic          act;
    logic [DW-1:0] rw;
  } tup_t;

  tup_t hist[$];
  int   total, mcount, nxt;
  int   checks, errors;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_chk(input string tag);
    chk(tag, {busy, input_enable, use_target, is_training,
              step_done, timeout_err, nn_input}, 32'd0);
  endtask

  task automatic model_clear();
    hist.delete();
    total  = 0;
    mcount = 0;
    nxt    = 0;
  endtask

  function automatic tup_t rnd_tup(input logic [DW-1:0] rw);
    tup_t t;
    t.st  = IW'($urandom);
    t.nx  = IW'($urandom);
    t.act = 1'($urandom);
    t.rw  = rw;
    return t;
  endfunction

  // accepted writes get consecutive sequence numbers; live window is
  // [total-mcount, total-1]
  task automatic wr(input tup_t t);
    bit rdy;
    rdy = OVW || (mcount < DEPTH);
    exp_valid      = 1'b1;
    exp_state      = t.st;
    exp_next_state = t.nx;
    exp_action     = t.act;
    exp_reward     = t.rw;
    chk("exp_ready", exp_ready, rdy);
    tick();
    exp_valid = 1'b0;
    if (rdy) begin
      hist.push_back(t);
      total++;
      if (mcount < DEPTH) mcount++;
      if (nxt < total - mcount) nxt = total - mcount;
    end
    chk("count", count, mcount);
  endtask

  task automatic model_sample(output tup_t t);
    int s;
    s   = nxt;
    t   = hist[s];
    nxt = (s == total - 1) ? total - mcount : s + 1;
  endtask

  task automatic noise(input bit en, input int st);
    if (en) begin
      start           = 1'($urandom);
      model_fwd_done  = (st != 0) ? 1'($urandom) : 1'b0;
      target_fwd_done = (st != 1) ? 1'($urandom) : 1'b0;
      training_done   = (st != 2) ? 1'($urandom) : 1'b0;
    end
  endtask

  task automatic quiet();
    start           = 1'b0;
    model_fwd_done  = 1'b0;
    target_fwd_done = 1'b0;
    training_done   = 1'b0;
  endtask

  task automatic step(input int lm, input int lt, input int ltr,
                      input bit nz);
    tup_t e;
    model_sample(e);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("load", {busy, input_enable, step_done}, 3'b100);
    tick();
    for (int i = 0; i <= lm; i++) begin
      chk("model", {busy, input_enable, use_target, is_training,
                    nn_input}, {4'b1100, e.st});
      chk("sel", {sel_action, sel_reward}, {e.act, e.rw});
      if (i == lm) model_fwd_done = 1'b1;
      else noise(nz, 0);
      tick();
      quiet();
    end
    chk("gap", {busy, input_enable, use_target, nn_input},
        {3'b100, IW'(0)});
    tick();
    for (int i = 0; i <= lt; i++) begin
      chk("target", {busy, input_enable, use_target, is_training,
                     nn_input}, {4'b1110, e.nx});
      if (i == lt) target_fwd_done = 1'b1;
      else noise(nz, 1);
      tick();
      quiet();
    end
    for (int i = 0; i <= ltr; i++) begin
      chk("train", {busy, input_enable, use_target, is_training,
                    step_done, nn_input}, {5'b10110, IW'(0)});
      if (i == ltr) training_done = 1'b1;
      else noise(nz, 2);
      tick();
      quiet();
    end
    chk("done", {busy, step_done, timeout_err}, 3'b110);
    tick();
    idle_chk("after_step");
    chk("sel_hold", {sel_action, sel_reward}, {e.act, e.rw});
  endtask

  initial begin
    tup_t e;
    tup_t ov[9];
    bit   early;
    checks = 0;
    errors = 0;
    model_clear();

    // reset
    tick();
    tick();
    idle_chk("reset");
    chk("reset_cnt", count, 0);
    chk("reset_sel", {sel_action, sel_reward}, 0);
    rst_b = 1'b0;
    tick();
    chk("ready_rst", exp_ready, 1);

    // start on empty buffer is ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("empty_start", busy, 0);
    tick();
    chk("empty_start2", busy, 0);

    // directed single tuple step
    e.st = 8'h21; e.nx = 8'h12; e.act = 1'b1; e.rw = 4'd5;
    wr(e);
    step(2, 1, 3, 1'b0);
    chk("dir_reward", sel_reward, 5);
    chk("dir_count", count, 1);

    // timeout while waiting for model forward pass
    model_sample(e);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    early = 1'b0;
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      if (timeout_err || step_done || !busy || !input_enable) early = 1'b1;
      tick();
    end
    chk("tmo_early", early, 0);
    chk("tmo_pulse", {timeout_err, busy}, 2'b11);
    tick();
    idle_chk("tmo_idle");
    chk("tmo_sel", sel_reward, e.rw);

    // random traffic with ignored out-of-state strobes and start
    repeat (25) begin
      int nw;
      nw = $urandom_range(0, 3);
      for (int k = 0; k < nw; k++) wr(rnd_tup(DW'($urandom)));
      if (mcount > 0)
        step($urandom_range(0, 4), $urandom_range(0, 4),
             $urandom_range(0, 4), 1'b1);
    end

    // reset in the middle of a target pass
    step(0, 0, 0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    model_fwd_done = 1'b1;
    tick();
    model_fwd_done = 1'b0;
    tick();
    chk("pre_rst_tgt", {input_enable, use_target}, 2'b11);
    rst_b = 1'b1;
    tick();
    idle_chk("mid_rst");
    chk("mid_rst_cnt", count, 0);
    chk("mid_rst_sel", {sel_action, sel_reward}, 0);
    rst_b = 1'b0;
    model_clear();
    tick();

    // fill past capacity
    for (int i = 0; i < 9; i++) begin
      ov[i] = rnd_tup(DW'(i + 1));
      wr(ov[i]);
    end
    chk("ovf_cnt", count, DEPTH);
    chk("ovf_ready", exp_ready, OVW);
    step(1, 1, 1, 1'b0);
    chk("ovf_first", sel_reward, OVW ? ov[1].rw : ov[0].rw);
    repeat (10) begin
      if ($urandom_range(0, 2) == 0) wr(rnd_tup(DW'($urandom)));
      step($urandom_range(0, 2), $urandom_range(0, 2),
           $urandom_range(0, 2), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/replay_sequencer.md
REPLAY_SEQUENCER -- requirements
Module: replay_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4, bits per neuron value.
REQ-002 SHALL have parameter NEURON_INPUT_LAYER, default 2, input neurons; IW = NEURON_INPUT_LAYER*DATA_WIDTH.
REQ-003 SHALL have parameter DEPTH, default 8, replay entries, power of two ≥2.
REQ-004 SHALL have parameter TIMEOUT, default 255, maximum wait cycles per handshake state.
REQ-005 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-006 SHALL have port rst_b, input, 1, synchronous active-high reset.
REQ-007 SHALL have port exp_valid / exp_ready, input / output, 1 each, experience write handshake.
REQ-008 SHALL have port exp_state and exp_next_state, input, IW each, observed state pair.
REQ-009 SHALL have port exp_action, input, 1, action taken; exp_reward, input, DATA_WIDTH, reward.
REQ-010 SHALL have port start, input, 1, request one training step; busy, output, 1.
REQ-011 SHALL have port nn_input, output, IW; input_enable, use_target, is_training, output, 1 each.
REQ-012 SHALL have port model_fwd_done, target_fwd_done, training_done, input, 1 each, network completion strobes.
REQ-013 SHALL have port sel_action, output, 1; sel_reward, output, DATA_WIDTH; sampled tuple fields.
REQ-014 SHALL have port step_done, timeout_err, output, 1 each, single-cycle pulses; count, output, $clog2(DEPTH+1).

Function
REQ-015 SHALL store a write on exp_valid&&exp_ready at wr_ptr, advance wr_ptr mod DEPTH, and increment count saturating at DEPTH.
REQ-016 SHALL implement FSM IDLE->LOAD->MODEL->GAP->TARGET->TRAIN->DONE->IDLE.
REQ-017 IDLE: start && count!=0 -> LOAD; start with count==0 or while busy SHALL be ignored.
REQ-018 LOAD (1 cycle): latch entry at smp_ptr into state/next/action/reward registers; advance smp_ptr, wrapping to oldest entry when it reaches the newest.
REQ-019 MODEL: nn_input=latched state, input_enable=1, use_target=0; model_fwd_done -> GAP.
REQ-020 GAP: input_enable=0 for exactly one cycle; -> TARGET.
REQ-021 TARGET: nn_input=latched next_state, input_enable=1, use_target=1; target_fwd_done -> TRAIN.
REQ-022 TRAIN: is_training=1, use_target=1, input_enable=0; training_done -> DONE.
REQ-023 DONE: step_done=1 for one cycle; -> IDLE.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 A wait counter SHALL clear on each entry to MODEL/TARGET/TRAIN; reaching TIMEOUT SHALL pulse timeout_err, skip step_done, return to IDLE.
REQ-026 Done strobes arriving outside their waiting state SHALL be ignored.
REQ-027 Write to the slot being read in the same LOAD cycle SHALL return the old data (read-before-write).
REQ-028 sel_action/sel_reward SHALL hold latched values from LOAD until the next LOAD.

Reset
REQ-029 rst_b=1 at any clock edge, including mid-step, SHALL force IDLE, count=0, wr_ptr=smp_ptr=0, all outputs 0.

Configuration
REQ-030 With REPLAY_OVERWRITE_EN defined, exp_ready SHALL be constant 1 and a full-buffer write SHALL overwrite the oldest entry, advancing the oldest pointer; undefined, exp_ready SHALL be 0 when count==DEPTH.

Structure
REQ-031 Package rlnn_pkg SHALL hold the FSM state enum and the experience struct typedef (state, next_state, action, reward).
REQ-032 Storage SHALL be sub-module replay_mem (circular array, one write, one registered-read port).

Verification
REQ-033 Reset, write 1 tuple (state 8'h21, next 8'h12, action 1, reward 5), pulse start -> LOAD then MODEL with nn_input=8'h21, input_enable=1, use_target=0.
REQ-034 Model_fwd_done then target_fwd_done then training_done -> one-cycle input_enable gap, nn_input=8'h12 with use_target=1, is_training=1, then step_done one cycle.
REQ-035 Start with count==0 -> busy stays 0; start while busy -> no second step.
REQ-036 Write 9 tuples into DEPTH 8: with REPLAY_OVERWRITE_EN, count=8 and first sample is tuple 2; without, exp_ready=0 after 8 and tuple 9 is dropped.
REQ-037 Withhold model_fwd_done 255 cycles -> timeout_err pulse, IDLE, no step_done.
REQ-038 Assert rst_b during TARGET -> next cycle IDLE, count=0, all outputs 0.
